pixel_scan_sequencer: RTL and testbench
=======================================

PIXEL_SCAN_SEQUENCER -- requirements
Module: pixel_scan_sequencer

Interface
REQ-001 SHALL have parameter N_COLS, default 32, length of sensor column select shift chain.
REQ-002 SHALL have parameter N_ROWS, default 32, length of sensor row select shift chain.
REQ-003 SHALL have parameter IDX_W, default 8, width of pixel index inputs.
REQ-004 SHALL have parameter TIMEOUT, default 4096, max clk cycles waiting on driver per command.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_start  input  1  request to select pixel (i_row, i_col).
REQ-008 SHALL have port i_col  input  IDX_W  target column index.
REQ-009 SHALL have port i_row  input  IDX_W  target row index.
REQ-010 SHALL have port o_busy  output  1  sequence in progress.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse, sequence completed.
REQ-012 SHALL have port o_err  output  1  one-cycle pulse, range error or driver timeout.
REQ-013 SHALL have port o_write_col  output  1  column-shift command strobe to chip driver.
REQ-014 SHALL have port o_write_row  output  1  row-shift command strobe to chip driver.
REQ-015 SHALL have port o_write_key  output  1  write-key command strobe to chip driver.
REQ-016 SHALL have port o_data_col  output  1  column bit, valid with o_write_col.
REQ-017 SHALL have port o_data_row  output  1  row bit, valid with o_write_row.
REQ-018 SHALL have port i_drv_rdy  input  1  chip driver idle/ready.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_ACK, WAIT_RDY, with phase register COL -> ROW -> KEY and bit counter k.
REQ-020 IDLE: i_start=1 with i_col<N_COLS and i_row<N_ROWS SHALL latch both indices, set phase=COL, k=0, go ISSUE; o_busy=1 from next cycle.
REQ-021 IDLE: i_start=1 with any index out of range SHALL pulse o_err next cycle, issue no command, stay IDLE.
REQ-022 i_start while o_busy=1 SHALL be ignored; latched indices SHALL not change.
REQ-023 ISSUE: when i_drv_rdy=1, SHALL assert exactly one strobe for exactly one cycle, then go WAIT_ACK; when i_drv_rdy=0, SHALL hold with no strobe.
REQ-024 Phase COL: strobe o_write_col, o_data_col=1 iff k==N_COLS-1-col, else 0 (first bit shifted lands deepest).
REQ-025 Phase ROW: strobe o_write_row, o_data_row=1 iff k==N_ROWS-1-row, else 0.
REQ-026 Phase KEY: strobe o_write_key, both data outputs 0.
REQ-027 Data outputs SHALL be 0 whenever their strobe is 0; at most one strobe high in any cycle.
REQ-028 WAIT_ACK: SHALL wait for i_drv_rdy=0, then go WAIT_RDY.
REQ-029 WAIT_RDY: on i_drv_rdy=1, SHALL advance: k+1 within phase; k wraps to 0 and COL->ROW after N_COLS commands, ROW->KEY after N_ROWS; after KEY go IDLE.
REQ-030 Completion: SHALL pulse o_done one cycle and drop o_busy the cycle after KEY acknowledged ready; total commands N_COLS+N_ROWS+1.
REQ-031 Timeout counter SHALL reset on each entry to ISSUE; exceeding TIMEOUT cycles in ISSUE/WAIT_ACK/WAIT_RDY SHALL pulse o_err, clear o_busy, go IDLE, no o_done.
REQ-032 o_done and o_err SHALL never assert in the same cycle.
REQ-033 k and timeout counters SHALL be sized via $clog2 of max(N_COLS,N_ROWS) and TIMEOUT+1.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, phase COL, k=0, counters 0, all outputs 0.
REQ-035 Reset mid-sequence SHALL abort without further strobes; first sequence after release SHALL start from k=0, phase COL.

Verification (N_COLS=4, N_ROWS=4, driver model drops rdy 1 cycle after strobe for 5 cycles)
REQ-036 start col=1,row=2 -> col bits 0,0,1,0; row bits 0,1,0,0; one key; o_done once; 9 strobes total.
REQ-037 start col=4,row=0 -> o_err one cycle, no strobes, o_busy stays 0.
REQ-038 driver holds rdy=0 for TIMEOUT+1 cycles after 3rd strobe -> o_err pulse, o_busy=0, no o_done.
REQ-039 second i_start col=3 during busy -> ignored; sequence completes with col=original.
REQ-040 rst=0 after 5th strobe, release, start col=0,row=3 -> col bits 0,0,0,1; row bits 1,0,0,0; o_done.
REQ-041 i_drv_rdy=0 at start for 10 cycles -> no strobe until rdy=1, then normal sequence.

Source files
------------

// File: rtl/pixel_scan_sequencer.sv
// pixel_scan_sequencer: shifts a one-hot column/row select pattern into a pixel
// sensor through a handshaked chip driver, then issues the write-key command.
`default_nettype none

module pixel_scan_sequencer #(
   parameter int N_COLS  = 32,
   parameter int N_ROWS  = 32,
   parameter int IDX_W   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [IDX_W-1:0] i_col,
   input  logic [IDX_W-1:0] i_row,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic             o_write_col,
   output logic             o_write_row,
   output logic             o_write_key,
   output logic             o_data_col,
   output logic             o_data_row,
   input  logic             i_drv_rdy
);

   localparam int K_MAX = (N_COLS > N_ROWS) ? N_COLS : N_ROWS;
   localparam int KW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;
   localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [KW-1:0] K_LAST_COL = KW'(N_COLS - 1);
   localparam logic [KW-1:0] K_LAST_ROW = KW'(N_ROWS - 1);
   localparam logic [TW-1:0] T_LIMIT    = TW'(TIMEOUT);
   localparam logic [31:0]   NC         = 32'(N_COLS);
   localparam logic [31:0]   NR         = 32'(N_ROWS);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_RDY} state_t;
   typedef enum logic [1:0] {PH_COL, PH_ROW, PH_KEY} phase_t;

   state_t           state, state_n;
   phase_t           phase, phase_n;
   logic [KW-1:0]    k, k_n;
   logic [TW-1:0]    tcnt, tcnt_n;
   logic [IDX_W-1:0] col_q, col_n, row_q, row_n;
   logic             busy_n, done_n, err_n;
   logic             wcol_n, wrow_n, wkey_n, dcol_n, drow_n;
   logic             timed_out;
   logic             in_range;
   logic             col_hit, row_hit;

   assign timed_out = (tcnt == T_LIMIT);
   assign in_range  = (32'(i_col) < NC) && (32'(i_row) < NR);
   // The first bit shifted ends up deepest in the chain, so the select bit
   // for index n has to go out on command N-1-n.
   assign col_hit   = (32'(k) == (NC - 32'd1 - 32'(col_q)));
   assign row_hit   = (32'(k) == (NR - 32'd1 - 32'(row_q)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         phase       <= PH_COL;
         k           <= '0;
         tcnt        <= '0;
         col_q       <= '0;
         row_q       <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
         o_write_col <= 1'b0;
         o_write_row <= 1'b0;
         o_write_key <= 1'b0;
         o_data_col  <= 1'b0;
         o_data_row  <= 1'b0;
      end else begin
         state       <= state_n;
         phase       <= phase_n;
         k           <= k_n;
         tcnt        <= tcnt_n;
         col_q       <= col_n;
         row_q       <= row_n;
         o_busy      <= busy_n;
         o_done      <= done_n;
         o_err       <= err_n;
         o_write_col <= wcol_n;
         o_write_row <= wrow_n;
         o_write_key <= wkey_n;
         o_data_col  <= dcol_n;
         o_data_row  <= drow_n;
      end
   end

   always_comb begin
      state_n = state;
      phase_n = phase;
      k_n     = k;
      tcnt_n  = tcnt;
      col_n   = col_q;
      row_n   = row_q;
      busy_n  = o_busy;
      done_n  = 1'b0;
      err_n   = 1'b0;
      wcol_n  = 1'b0;
      wrow_n  = 1'b0;
      wkey_n  = 1'b0;
      dcol_n  = 1'b0;
      drow_n  = 1'b0;

      case (state)
         IDLE: begin
            if (i_start) begin
               if (in_range) begin
                  col_n   = i_col;
                  row_n   = i_row;
                  phase_n = PH_COL;
                  k_n     = '0;
                  tcnt_n  = '0;
                  busy_n  = 1'b1;
                  state_n = ISSUE;
               end else begin
                  err_n = 1'b1;
               end
            end
         end

         ISSUE, WAIT_ACK, WAIT_RDY: begin
            if (timed_out) begin
               // Driver never answered: abandon the sequence without done.
               state_n = IDLE;
               phase_n = PH_COL;
               k_n     = '0;
               tcnt_n  = '0;
               busy_n  = 1'b0;
               err_n   = 1'b1;
            end else begin
               tcnt_n = tcnt + 1'b1;
               if (state == ISSUE) begin
                  if (i_drv_rdy) begin
                     state_n = WAIT_ACK;
                     case (phase)
                        PH_COL: begin
                           wcol_n = 1'b1;
                           dcol_n = col_hit;
                        end
                        PH_ROW: begin
                           wrow_n = 1'b1;
                           drow_n = row_hit;
                        end
                        default: wkey_n = 1'b1;
                     endcase
                  end
               end else if (state == WAIT_ACK) begin
                  if (!i_drv_rdy) state_n = WAIT_RDY;
               end else if (i_drv_rdy) begin
                  tcnt_n  = '0;
                  state_n = ISSUE;
                  case (phase)
                     PH_COL: begin
                        if (k == K_LAST_COL) begin
                           k_n     = '0;
                           phase_n = PH_ROW;
                        end else begin
                           k_n = k + 1'b1;
                        end
                     end
                     PH_ROW: begin
                        if (k == K_LAST_ROW) begin
                           k_n     = '0;
                           phase_n = PH_KEY;
                        end else begin
                           k_n = k + 1'b1;
                        end
                     end
                     default: begin
                        state_n = IDLE;
                        phase_n = PH_COL;
                        k_n     = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                     end
                  endcase
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_pixel_scan_sequencer.sv
// tb_pixel_scan_sequencer: randomized and directed checks of the pixel scan
// sequencer against a shift-chain model with a handshaking driver model.
`default_nettype none

module tb_pixel_scan_sequencer;

   localparam int N_COLS  = 4;
   localparam int N_ROWS  = 4;
   localparam int IDX_W   = 8;
   localparam int TIMEOUT = 64;
   localparam int HOLD    = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_start;
   logic [IDX_W-1:0] i_col, i_row;
   logic             i_drv_rdy;
   logic             o_busy, o_done, o_err;
   logic             o_write_col, o_write_row, o_write_key;
   logic             o_data_col, o_data_row;

   pixel_scan_sequencer #(
      .N_COLS (N_COLS),
      .N_ROWS (N_ROWS),
      .IDX_W  (IDX_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_col      (i_col),
      .i_row      (i_row),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_err      (o_err),
      .o_write_col(o_write_col),
      .o_write_row(o_write_row),
      .o_write_key(o_write_key),
      .o_data_col (o_data_col),
      .o_data_row (o_data_row),
      .i_drv_rdy  (i_drv_rdy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Sensor chain model and event counters, fed by the monitor below.
   int col_chain, row_chain, col_cnt, row_cnt, key_cnt;
   int done_cnt, err_cnt, busy_cnt, viol_cnt;
   int strobe_tot = 0;
   int stall_at   = -1;
   int stall_len  = 0;
   int low_left   = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   initial begin : drv_mon
      int w;
      i_drv_rdy = 1'b1;
      forever begin
         @(negedge clk);
         w = int'(o_write_col) + int'(o_write_row) + int'(o_write_key);
         if (w > 1) viol_cnt++;
         if (!o_write_col && o_data_col) viol_cnt++;
         if (!o_write_row && o_data_row) viol_cnt++;
         if (o_done && o_err) viol_cnt++;
         if (o_write_col) begin
            col_chain = ((col_chain << 1) | int'(o_data_col)) & ((1 << N_COLS) - 1);
            col_cnt++;
         end
         if (o_write_row) begin
            row_chain = ((row_chain << 1) | int'(o_data_row)) & ((1 << N_ROWS) - 1);
            row_cnt++;
         end
         if (o_write_key) key_cnt++;
         if (o_done) done_cnt++;
         if (o_err) err_cnt++;
         if (o_busy) busy_cnt++;
         if (w > 0) begin
            strobe_tot++;
            low_left = (strobe_tot == stall_at) ? stall_len : HOLD;
         end
         if (low_left > 0) begin
            i_drv_rdy = 1'b0;
            low_left--;
         end else begin
            i_drv_rdy = 1'b1;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon;
      col_chain = 0; row_chain = 0; col_cnt = 0; row_cnt = 0; key_cnt = 0;
      done_cnt = 0; err_cnt = 0; busy_cnt = 0; viol_cnt = 0;
   endtask

   task automatic pulse_start(input int c, input int r);
      i_start = 1'b1;
      i_col   = IDX_W'(c);
      i_row   = IDX_W'(r);
      tick;
      i_start = 1'b0;
   endtask

   task automatic wait_end;
      int t = 0;
      while (done_cnt + err_cnt == 0 && t < 1000) begin
         tick;
         t++;
      end
      tick;
      tick;
      check_val("seq_end", (done_cnt + err_cnt > 0) ? 1 : 0, 1);
   endtask

   task automatic check_result(input int c, input int r);
      if (c < N_COLS && r < N_ROWS) begin
         check_val("col_select", col_chain, 1 << c);
         check_val("row_select", row_chain, 1 << r);
         check_val("col_cmds", col_cnt, N_COLS);
         check_val("row_cmds", row_cnt, N_ROWS);
         check_val("key_cmds", key_cnt, 1);
         check_val("done_pulses", done_cnt, 1);
         check_val("err_pulses", err_cnt, 0);
         check_val("busy_seen", (busy_cnt > 0) ? 1 : 0, 1);
         check_val("busy_after", int'(o_busy), 0);
         check_val("protocol_viol", viol_cnt, 0);
      end else begin
         check_val("range_err", err_cnt, 1);
         check_val("range_strobes", col_cnt + row_cnt + key_cnt, 0);
         check_val("range_busy", busy_cnt, 0);
         check_val("range_done", done_cnt, 0);
      end
   endtask

   initial begin : main
      int base, t, c, r;
      rst = 1'b0; i_start = 1'b0; i_col = '0; i_row = '0;
      clear_mon;
      repeat (3) tick;
      check_val("rst_busy", int'(o_busy), 0);
      check_val("rst_done", int'(o_done), 0);
      check_val("rst_err", int'(o_err), 0);
      check_val("rst_strobes", int'({o_write_col, o_write_row, o_write_key, o_data_col, o_data_row}), 0);
      rst = 1'b1;
      tick;

      clear_mon; pulse_start(1, 2); wait_end; check_result(1, 2);
      check_val("total_strobes", col_cnt + row_cnt + key_cnt, N_COLS + N_ROWS + 1);

      clear_mon; pulse_start(4, 0); wait_end; check_result(4, 0);

      // Driver not ready at start: nothing may be issued until it is.
      clear_mon; low_left = 10; pulse_start(2, 1);
      repeat (6) tick;
      check_val("hold_nostrobe", col_cnt + row_cnt + key_cnt, 0);
      wait_end; check_result(2, 1);

      // A second start while busy must not disturb the latched target.
      clear_mon; pulse_start(0, 3);
      repeat (10) tick;
      pulse_start(3, 1);
      wait_end; check_result(0, 3);

      // Driver stalls after the third command long enough to time out.
      clear_mon; stall_at = strobe_tot + 3; stall_len = TIMEOUT + 1;
      pulse_start(3, 3); wait_end;
      check_val("to_err", err_cnt, 1);
      check_val("to_done", done_cnt, 0);
      check_val("to_busy", int'(o_busy), 0);
      check_val("to_strobes", col_cnt + row_cnt + key_cnt, 3);
      repeat (TIMEOUT + 10) tick;
      check_val("to_quiet", col_cnt + row_cnt + key_cnt, 3);
      stall_at = -1;

      // Reset in the middle of a sequence, then a fresh sequence.
      clear_mon; base = strobe_tot; pulse_start(2, 2);
      t = 0;
      while (strobe_tot - base < 5 && t < 500) begin
         tick;
         t++;
      end
      check_val("pre_rst_strobes", strobe_tot - base, 5);
      rst = 1'b0;
      clear_mon;
      repeat (4) tick;
      check_val("rst_mid_busy", int'(o_busy), 0);
      check_val("rst_mid_strobes", col_cnt + row_cnt + key_cnt, 0);
      rst = 1'b1;
      tick;
      clear_mon; pulse_start(0, 3); wait_end; check_result(0, 3);

      for (int i = 0; i < 16; i++) begin
         c = int'($urandom_range(0, 5));
         r = int'($urandom_range(0, 5));
         clear_mon; pulse_start(c, r); wait_end; check_result(c, r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
